// File: rtl/multicycle_control_unit_if.sv
// Control interface between the multi-cycle control unit and the 16-bit bus datapath.
// master: control unit (drives every control strobe, receives IR contents).
// slave : datapath (receives control strobes, supplies IR contents).
interface multicycle_control_unit_if;
  logic [15:0] IR_Read_Data;
  logic        PCRead, PCWrite, PCReset, Cond_PCWrite;
  logic        MARSrc, MARWrite;
  logic        MDRSrc, MDRWrite, MDRRead;
  logic        MB1_Mem_Read, MB1_Mem_Write;
  logic        IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read;
  logic        Const_2_Read, Const_0_Read;
  logic        RegFile_Read, RegFileWrite;
  logic [1:0]  RegNumberSrc;
  logic [1:0]  WD_RegFileSrc;
  logic [2:0]  ALU_Control_Signal;
  logic [1:0]  Jump_Flag_Select;
  logic        M_Write, Z_Write, O_Write, C_Write;
  logic        Halted;

  modport master (
    input  IR_Read_Data,
    output PCRead, PCWrite, PCReset, Cond_PCWrite, MARSrc, MARWrite,
           MDRSrc, MDRWrite, MDRRead, MB1_Mem_Read, MB1_Mem_Write,
           IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read,
           Const_2_Read, Const_0_Read, RegFile_Read, RegFileWrite,
           RegNumberSrc, WD_RegFileSrc, ALU_Control_Signal, Jump_Flag_Select,
           M_Write, Z_Write, O_Write, C_Write, Halted
  );

  modport slave (
    output IR_Read_Data,
    input  PCRead, PCWrite, PCReset, Cond_PCWrite, MARSrc, MARWrite,
           MDRSrc, MDRWrite, MDRRead, MB1_Mem_Read, MB1_Mem_Write,
           IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read,
           Const_2_Read, Const_0_Read, RegFile_Read, RegFileWrite,
           RegNumberSrc, WD_RegFileSrc, ALU_Control_Signal, Jump_Flag_Select,
           M_Write, Z_Write, O_Write, C_Write, Halted
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control FSM for the 16-bit bus datapath.
// Issues fetch / decode / execute control sequences (ALU, LOAD, STORE, JUMP,
// NOP, HALT). Outputs are registered: each edge loads the decode of the state
// being entered, so outputs are a pure function of the current state.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   Step   - single-step enable (only when SINGLE_STEP_EN is defined)
//   bus    - multicycle_control_unit_if.master: IR in, all control strobes out
// Parameter MEM_WAIT: cycles a memory strobe is held (1..15, 0 acts as 1).
// Optional macro SINGLE_STEP_EN: F1 is entered only with Step high, else STALL.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic clk,
  input logic reset,
`ifdef SINGLE_STEP_EN
  input logic Step,
`endif
  multicycle_control_unit_if.master bus
);

  typedef enum logic [4:0] {
    ST_RST, ST_F1, ST_F2, ST_F3, ST_DEC,
    ST_A1, ST_A2, ST_A3,
    ST_L1, ST_L2, ST_L3,
    ST_S1, ST_S2, ST_S3, ST_S4,
    ST_J1, ST_J2,
    ST_HALT, ST_STALL
  } state_t;

  typedef struct packed {
    logic       PCRead, PCWrite, PCReset, Cond_PCWrite;
    logic       MARSrc, MARWrite;
    logic       MDRSrc, MDRWrite, MDRRead;
    logic       MB1_Mem_Read, MB1_Mem_Write;
    logic       IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read;
    logic       Const_2_Read, Const_0_Read;
    logic       RegFile_Read, RegFileWrite;
    logic [1:0] RegNumberSrc;
    logic [1:0] WD_RegFileSrc;
    logic [2:0] ALU_Control_Signal;
    logic [1:0] Jump_Flag_Select;
    logic       M_Write, Z_Write, O_Write, C_Write;
    logic       Halted;
  } ctl_t;

  // Counter reload value: strobe is held WAIT_LOAD+1 cycles.
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT <= 1) ? 4'd0 : 4'(MEM_WAIT - 1);

  state_t      state, nxt, after;
  logic [3:0]  cnt, cnt_nxt;
  logic        hold;   // keeps RST for one full cycle after reset releases
  ctl_t        ctl;
  logic        go;
  logic [15:0] ir;

  assign ir = bus.IR_Read_Data;

`ifdef SINGLE_STEP_EN
  assign go = Step;
`else
  assign go = 1'b1;
`endif

  // Where to go at the end of an instruction (or out of RST / STALL).
  assign after = go ? ST_F1 : ST_STALL;

  function automatic ctl_t decode(state_t s, logic [15:0] irv);
    ctl_t c;
    c = '0;
    case (s)
      ST_RST:  begin c.PCReset = 1'b1; c.PCWrite = 1'b1; end
      ST_F1:   begin c.PCRead = 1'b1; c.MARSrc = 1'b1; c.MARWrite = 1'b1; c.TWrite = 1'b1; end
      ST_F2:   begin c.MB1_Mem_Read = 1'b1; c.MDRWrite = 1'b1; c.Const_2_Read = 1'b1; end
      ST_F3:   begin c.ALUOutRead = 1'b1; c.PCWrite = 1'b1; c.MDRRead = 1'b1; c.IRWrite = 1'b1; end
      ST_A1, ST_J1: begin
        c.RegNumberSrc = 2'd1; c.RegFile_Read = 1'b1; c.TWrite = 1'b1;
      end
      ST_A2: begin
        c.RegNumberSrc = 2'd0; c.RegFile_Read = 1'b1;
        c.ALU_Control_Signal = irv[2:0];
        c.ALUOutRead = 1'b1; c.ALUOutWrite = 1'b1;
        c.M_Write = 1'b1; c.Z_Write = 1'b1; c.O_Write = 1'b1; c.C_Write = 1'b1;
      end
      ST_A3:   begin c.ALUOut_Reg_Read = 1'b1; c.RegNumberSrc = 2'd2; c.RegFileWrite = 1'b1; end
      ST_L1, ST_S1: begin
        c.RegNumberSrc = 2'd1; c.RegFile_Read = 1'b1; c.MARSrc = 1'b1; c.MARWrite = 1'b1;
      end
      ST_L2:   begin c.MB1_Mem_Read = 1'b1; c.MDRWrite = 1'b1; end
      ST_L3:   begin c.MDRRead = 1'b1; c.RegNumberSrc = 2'd2; c.RegFileWrite = 1'b1; end
      ST_S2:   begin c.RegNumberSrc = 2'd0; c.RegFile_Read = 1'b1; c.TWrite = 1'b1; end
      ST_S3:   begin c.Const_0_Read = 1'b1; c.ALUOutRead = 1'b1; c.MDRSrc = 1'b1; c.MDRWrite = 1'b1; end
      ST_S4:   c.MB1_Mem_Write = 1'b1;
      ST_J2: begin
        c.Const_0_Read = 1'b1; c.ALUOutRead = 1'b1;
        c.Jump_Flag_Select = irv[9:8]; c.Cond_PCWrite = 1'b1;
      end
      ST_HALT: c.Halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt     = state;
    cnt_nxt = 4'd0;   // cleared whenever the counter is not in use
    case (state)
      ST_RST:  nxt = hold ? ST_RST : after;
      ST_F1:   begin nxt = ST_F2; cnt_nxt = WAIT_LOAD; end
      ST_F2:   if (cnt == 4'd0) nxt = ST_F3; else cnt_nxt = cnt - 4'd1;
      ST_F3:   nxt = ST_DEC;
      ST_DEC: begin
        casez (ir[3:0])
          4'b0???: nxt = ST_A1;
          4'b1000: nxt = ST_L1;
          4'b1001: nxt = ST_S1;
          4'b1010: nxt = ST_J1;
          4'b1111: nxt = ST_HALT;
          default: nxt = after;
        endcase
      end
      ST_A1:   nxt = ST_A2;
      ST_A2:   nxt = ST_A3;
      ST_A3:   nxt = after;
      ST_L1:   begin nxt = ST_L2; cnt_nxt = WAIT_LOAD; end
      ST_L2:   if (cnt == 4'd0) nxt = ST_L3; else cnt_nxt = cnt - 4'd1;
      ST_L3:   nxt = after;
      ST_S1:   nxt = ST_S2;
      ST_S2:   nxt = ST_S3;
      ST_S3:   begin nxt = ST_S4; cnt_nxt = WAIT_LOAD; end
      ST_S4:   if (cnt == 4'd0) nxt = after; else cnt_nxt = cnt - 4'd1;
      ST_J1:   nxt = ST_J2;
      ST_J2:   nxt = after;
      ST_HALT: nxt = ST_HALT;
      ST_STALL: nxt = after;
      default: nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
      cnt   <= 4'd0;
      hold  <= 1'b1;
      ctl   <= decode(ST_RST, 16'h0000);
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      hold  <= 1'b0;
      ctl   <= decode(nxt, ir);
    end
  end

  // Only opcode, ALU function and flag-select bits steer control.
  logic unused_ir;
  assign unused_ir = ^{ir[15:10], ir[7:4]};

  assign bus.PCRead             = ctl.PCRead;
  assign bus.PCWrite            = ctl.PCWrite;
  assign bus.PCReset            = ctl.PCReset;
  assign bus.Cond_PCWrite       = ctl.Cond_PCWrite;
  assign bus.MARSrc             = ctl.MARSrc;
  assign bus.MARWrite           = ctl.MARWrite;
  assign bus.MDRSrc             = ctl.MDRSrc;
  assign bus.MDRWrite           = ctl.MDRWrite;
  assign bus.MDRRead            = ctl.MDRRead;
  assign bus.MB1_Mem_Read       = ctl.MB1_Mem_Read;
  assign bus.MB1_Mem_Write      = ctl.MB1_Mem_Write;
  assign bus.IRWrite            = ctl.IRWrite;
  assign bus.TWrite             = ctl.TWrite;
  assign bus.ALUOutWrite        = ctl.ALUOutWrite;
  assign bus.ALUOutRead         = ctl.ALUOutRead;
  assign bus.ALUOut_Reg_Read    = ctl.ALUOut_Reg_Read;
  assign bus.Const_2_Read       = ctl.Const_2_Read;
  assign bus.Const_0_Read       = ctl.Const_0_Read;
  assign bus.RegFile_Read       = ctl.RegFile_Read;
  assign bus.RegFileWrite       = ctl.RegFileWrite;
  assign bus.RegNumberSrc       = ctl.RegNumberSrc;
  assign bus.WD_RegFileSrc      = ctl.WD_RegFileSrc;
  assign bus.ALU_Control_Signal = ctl.ALU_Control_Signal;
  assign bus.Jump_Flag_Select   = ctl.Jump_Flag_Select;
  assign bus.M_Write            = ctl.M_Write;
  assign bus.Z_Write            = ctl.Z_Write;
  assign bus.O_Write            = ctl.O_Write;
  assign bus.C_Write            = ctl.C_Write;
  assign bus.Halted             = ctl.Halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control-word table for
// each instruction class at MEM_WAIT=1, plus hand sequences for MEM_WAIT=3
// LOAD timing, HALT hold / async reset, and reset abort during STORE write.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  always #5 clk = ~clk;

  multicycle_control_unit_if bus1();
  multicycle_control_unit_if bus3();

  multicycle_control_unit #(.MEM_WAIT(1)) u_dut1 (
    .clk(clk), .reset(rst1),
`ifdef SINGLE_STEP_EN
    .Step(step),
`endif
    .bus(bus1.master));

  multicycle_control_unit #(.MEM_WAIT(3)) u_dut3 (
    .clk(clk), .reset(rst3),
`ifdef SINGLE_STEP_EN
    .Step(step),
`endif
    .bus(bus3.master));

  // Packed observation word; bit positions match the localparams below.
  logic [33:0] w1, w3;
  assign w1 = {bus1.Jump_Flag_Select, bus1.ALU_Control_Signal, bus1.WD_RegFileSrc,
               bus1.RegNumberSrc, bus1.Halted, bus1.C_Write, bus1.O_Write, bus1.Z_Write,
               bus1.M_Write, bus1.RegFileWrite, bus1.RegFile_Read, bus1.Const_0_Read,
               bus1.Const_2_Read, bus1.ALUOut_Reg_Read, bus1.ALUOutRead, bus1.ALUOutWrite,
               bus1.TWrite, bus1.IRWrite, bus1.MB1_Mem_Write, bus1.MB1_Mem_Read,
               bus1.MDRRead, bus1.MDRWrite, bus1.MDRSrc, bus1.MARWrite, bus1.MARSrc,
               bus1.Cond_PCWrite, bus1.PCReset, bus1.PCWrite, bus1.PCRead};
  assign w3 = {bus3.Jump_Flag_Select, bus3.ALU_Control_Signal, bus3.WD_RegFileSrc,
               bus3.RegNumberSrc, bus3.Halted, bus3.C_Write, bus3.O_Write, bus3.Z_Write,
               bus3.M_Write, bus3.RegFileWrite, bus3.RegFile_Read, bus3.Const_0_Read,
               bus3.Const_2_Read, bus3.ALUOut_Reg_Read, bus3.ALUOutRead, bus3.ALUOutWrite,
               bus3.TWrite, bus3.IRWrite, bus3.MB1_Mem_Write, bus3.MB1_Mem_Read,
               bus3.MDRRead, bus3.MDRWrite, bus3.MDRSrc, bus3.MARWrite, bus3.MARSrc,
               bus3.Cond_PCWrite, bus3.PCReset, bus3.PCWrite, bus3.PCRead};

  localparam logic [33:0] PCRD  = 34'h1 << 0;
  localparam logic [33:0] PCWR  = 34'h1 << 1;
  localparam logic [33:0] PCRST = 34'h1 << 2;
  localparam logic [33:0] CPCWR = 34'h1 << 3;
  localparam logic [33:0] MARS  = 34'h1 << 4;
  localparam logic [33:0] MARW  = 34'h1 << 5;
  localparam logic [33:0] MDRS  = 34'h1 << 6;
  localparam logic [33:0] MDRW  = 34'h1 << 7;
  localparam logic [33:0] MDRR  = 34'h1 << 8;
  localparam logic [33:0] MRD   = 34'h1 << 9;
  localparam logic [33:0] MWR   = 34'h1 << 10;
  localparam logic [33:0] IRW   = 34'h1 << 11;
  localparam logic [33:0] TW    = 34'h1 << 12;
  localparam logic [33:0] AOW   = 34'h1 << 13;
  localparam logic [33:0] AOR   = 34'h1 << 14;
  localparam logic [33:0] AORG  = 34'h1 << 15;
  localparam logic [33:0] C2    = 34'h1 << 16;
  localparam logic [33:0] C0    = 34'h1 << 17;
  localparam logic [33:0] RFR   = 34'h1 << 18;
  localparam logic [33:0] RFW   = 34'h1 << 19;
  localparam logic [33:0] FLAGS = 34'hF << 20;
  localparam logic [33:0] HLT   = 34'h1 << 24;

  function automatic logic [33:0] rns(int v);  return 34'(v) << 25; endfunction
  function automatic logic [33:0] alu(int v);  return 34'(v) << 29; endfunction
  function automatic logic [33:0] jfs(int v);  return 34'(v) << 32; endfunction

  localparam logic [33:0] W_RST = PCRST | PCWR;
  localparam logic [33:0] W_F1  = PCRD | MARS | MARW | TW;
  localparam logic [33:0] W_F2  = MRD | MDRW | C2;
  localparam logic [33:0] W_F3  = AOR | PCWR | MDRR | IRW;
  localparam logic [33:0] W_DEC = 34'h0;

  typedef struct {
    string       name;
    logic        start;
    logic [15:0] ir;
    logic [33:0] exp;
  } vec_t;

  vec_t rows[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic st, input logic [15:0] ir, input logic [33:0] e);
    vec_t v;
    v.name = nm; v.start = st; v.ir = ir; v.exp = e;
    rows.push_back(v);
  endtask

  task automatic add_fetch(input string nm, input logic [15:0] ir);
    add({nm, "_f1"}, 1'b1, ir, W_F1);
    add({nm, "_f2"}, 1'b0, ir, W_F2);
    add({nm, "_f3"}, 1'b0, ir, W_F3);
    add({nm, "_dec"}, 1'b0, ir, W_DEC);
  endtask

  // Reset pulse on dut1; returns sampling the F1 cycle (2 edges after release).
  task automatic reset1(input logic [15:0] ir);
    rst1 = 1'b1;
    bus1.IR_Read_Data = ir;
    @(posedge clk); #1;
    chk("reset_out", w1, W_RST);
    rst1 = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold", w1, W_RST);
    @(posedge clk); #1;
  endtask

  initial begin
    int rd_f, rd_x, period;
    logic seen_ir;
    int hcnt;

    bus1.IR_Read_Data = 16'h0000;
    bus3.IR_Read_Data = 16'h1008;

    // ALU add r0,r4,r0
    add_fetch("add", 16'h0000);
    add("add_a1", 0, 16'h0000, rns(1) | RFR | TW);
    add("add_a2", 0, 16'h0000, rns(0) | RFR | alu(0) | AOR | AOW | FLAGS);
    add("add_a3", 0, 16'h0000, AORG | rns(2) | RFW);
    add("add_nx", 0, 16'h0000, W_F1);
    // ALU function 101 carried from IR[2:0]
    add_fetch("alu5", 16'hE405);
    add("alu5_a1", 0, 16'hE405, rns(1) | RFR | TW);
    add("alu5_a2", 0, 16'hE405, rns(0) | RFR | alu(5) | AOR | AOW | FLAGS);
    add("alu5_a3", 0, 16'hE405, AORG | rns(2) | RFW);
    add("alu5_nx", 0, 16'hE405, W_F1);
    // LOAD
    add_fetch("ld", 16'h1008);
    add("ld_l1", 0, 16'h1008, rns(1) | RFR | MARS | MARW);
    add("ld_l2", 0, 16'h1008, MRD | MDRW);
    add("ld_l3", 0, 16'h1008, MDRR | rns(2) | RFW);
    add("ld_nx", 0, 16'h1008, W_F1);
    // STORE
    add_fetch("st", 16'h0009);
    add("st_s1", 0, 16'h0009, rns(1) | RFR | MARS | MARW);
    add("st_s2", 0, 16'h0009, rns(0) | RFR | TW);
    add("st_s3", 0, 16'h0009, C0 | AOR | MDRS | MDRW);
    add("st_s4", 0, 16'h0009, MWR);
    add("st_nx", 0, 16'h0009, W_F1);
    // JUMP sense 0 / sense 1 / flag select 11
    add_fetch("j0", 16'h000A);
    add("j0_j1", 0, 16'h000A, rns(1) | RFR | TW);
    add("j0_j2", 0, 16'h000A, C0 | AOR | jfs(0) | CPCWR);
    add("j0_nx", 0, 16'h000A, W_F1);
    add_fetch("j1", 16'h008A);
    add("j1_j1", 0, 16'h008A, rns(1) | RFR | TW);
    add("j1_j2", 0, 16'h008A, C0 | AOR | jfs(0) | CPCWR);
    add("j1_nx", 0, 16'h008A, W_F1);
    add_fetch("j3", 16'h030A);
    add("j3_j1", 0, 16'h030A, rns(1) | RFR | TW);
    add("j3_j2", 0, 16'h030A, C0 | AOR | jfs(3) | CPCWR);
    add("j3_nx", 0, 16'h030A, W_F1);
    // NOP opcodes
    add_fetch("nopb", 16'h000B);
    add("nopb_nx", 0, 16'h000B, W_F1);
    add_fetch("nope", 16'h000E);
    add("nope_nx", 0, 16'h000E, W_F1);

    foreach (rows[i]) begin
      if (rows[i].start) reset1(rows[i].ir);
      chk(rows[i].name, w1, rows[i].exp);
      @(posedge clk); #1;
    end

    // MEM_WAIT=3 LOAD: 3-cycle read strobes, 11-cycle instruction
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mw3_f1", w3, W_F1);
    rd_f = 0; rd_x = 0; period = 0; seen_ir = 1'b0;
    for (int k = 1; k <= 30 && period == 0; k++) begin
      @(posedge clk); #1;
      if (bus3.PCRead) period = k;
      else begin
        if (bus3.MB1_Mem_Read) begin
          if (seen_ir) rd_x++; else rd_f++;
        end
        if (bus3.IRWrite) seen_ir = 1'b1;
      end
    end
    chk_i("mw3_f2_reads", rd_f, 3);
    chk_i("mw3_l2_reads", rd_x, 3);
    chk_i("mw3_period", period, 11);

    // HALT: hold, then async reset clears it immediately, F1 follows
    reset1(16'h000F);
    repeat (4) begin @(posedge clk); #1; end
    chk("halt_enter", w1, HLT);
    hcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus1.Halted) hcnt++;
    end
    chk_i("halt_hold", hcnt, 20);
    #2 rst1 = 1'b1;
    #1 chk("halt_async_rst", w1, W_RST);
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(posedge clk); #1;
    chk("halt_rst_hold", w1, W_RST);
    @(posedge clk); #1;
    chk("halt_then_f1", w1, W_F1);

    // Reset during S4: memory write strobe drops at once
    reset1(16'h0009);
    repeat (7) begin @(posedge clk); #1; end
    chk("s4_before", w1, MWR);
    #2 rst1 = 1'b1;
    #1 chk("s4_abort", w1, W_RST);
    @(posedge clk); #1;
    chk("s4_rst_state", w1, W_RST);
    rst1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("s4_then_f1", w1, W_F1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
